// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared types and constants for the change dispenser: the
//            controller state enum, change codes in 5c units, and coin values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VEND     = 3'd1,
    ST_SELECT   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  // Change codes carried on change_i, in 5c units.
  localparam logic [2:0] CHG_0  = 3'd0;
  localparam logic [2:0] CHG_5  = 3'd1;
  localparam logic [2:0] CHG_10 = 3'd2;
  localparam logic [2:0] CHG_15 = 3'd3;
  localparam logic [2:0] CHG_20 = 3'd4;

  // Coin values in 5c units.
  localparam logic [2:0] NICKLE_VAL = 3'd1;
  localparam logic [2:0] DIME_VAL   = 3'd2;

endpackage
`default_nettype wire

// File: rtl/coin_inventory.sv
`default_nettype none
// ============================================================================
// Module   : coin_inventory
// Purpose  : One coin-tube inventory counter. Loads INIT on reset or load_i,
//            counts down on dec_i, and never wraps below zero.
// Ports    : clk_i, rst_ni      - clock, async active-low reset
//            load_i             - synchronous reload to INIT (wins over dec_i)
//            dec_i              - remove one coin
//            cnt_o              - current count
//            nz_o               - count is nonzero
// Revision : 1.0 - initial release
// ============================================================================
module coin_inventory #(
  parameter int CNT_W = 4,
  parameter int INIT  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o
);

  localparam logic [CNT_W-1:0] INIT_V = INIT[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = INIT_V;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= INIT_V;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Releases a soda on each sale strobe, then pays the owed change
//            one coin at a time (dimes first, never overpaying) through a
//            request/acknowledge coin mechanism. Stalls in FAULT when stock
//            cannot cover the remainder until a refill arrives.
// Ports    : clk_i, rst_ni            - clock, async active-low reset
//            soda_i, change_i[2:0]    - sale strobe and change owed (5c units)
//            coin_ack_i               - coin ejected
//            refill_i                 - restock both tubes
//            vend_o                   - one-cycle soda release
//            nickle_o, dime_o         - coin eject requests
//            busy_o, fault_o, err_o   - status
//            nickle_cnt_o, dime_cnt_o - inventory counts
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser
  import vend_pkg::*;
#(
  parameter int NICKLE_INIT = 8,
  parameter int DIME_INIT   = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             soda_i,
  input  logic [2:0]       change_i,
  input  logic             coin_ack_i,
  input  logic             refill_i,
  output logic             vend_o,
  output logic             nickle_o,
  output logic             dime_o,
  output logic             busy_o,
  output logic             fault_o,
  output logic             err_o,
  output logic [CNT_W-1:0] nickle_cnt_o,
  output logic [CNT_W-1:0] dime_cnt_o
);

  state_e     state_q, state_d;
  logic [2:0] rem_q, rem_d;     // change still owed, 5c units
  logic       coin_q, coin_d;   // coin being paid: 1 = dime, 0 = nickel
  logic       err_q, err_d;

  logic load;
  logic dec_nickle, dec_dime;
  logic nickle_nz, dime_nz;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    coin_d     = coin_q;
    load       = 1'b0;
    dec_nickle = 1'b0;
    dec_dime   = 1'b0;
    // A strobe is rejected when a sale is already running or the code is
    // out of range; either way err_o pulses in the following cycle.
    err_d      = soda_i && ((state_q != ST_IDLE) || (change_i > CHG_20));

    unique case (state_q)
      ST_IDLE: begin
        load = refill_i;
        if (soda_i) begin
          // Out-of-range codes still sell the soda, just with no change.
          rem_d   = (change_i > CHG_20) ? CHG_0 : change_i;
          state_d = ST_VEND;
        end
      end
      ST_VEND: begin
        load    = refill_i;
        state_d = ST_SELECT;
      end
      ST_SELECT: begin
        // Decision uses the counts as they stand this cycle; a concurrent
        // refill only takes effect from the next cycle.
        load = refill_i;
        if (rem_q == CHG_0) begin
          state_d = ST_IDLE;
        end else if ((rem_q >= DIME_VAL) && dime_nz) begin
          coin_d  = 1'b1;
          state_d = ST_WAIT_ACK;
        end else if (nickle_nz) begin
          coin_d  = 1'b0;
          state_d = ST_WAIT_ACK;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_WAIT_ACK: begin
        if (coin_ack_i) begin
          rem_d      = rem_q - (coin_q ? DIME_VAL : NICKLE_VAL);
          dec_dime   = coin_q;
          dec_nickle = !coin_q;
          state_d    = ST_SELECT;
        end
      end
      ST_FAULT: begin
        if (refill_i) begin
          load    = 1'b1;
          state_d = ST_SELECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rem_q   <= CHG_0;
      coin_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
      err_q   <= err_d;
    end
  end

  coin_inventory #(
    .CNT_W (CNT_W),
    .INIT  (NICKLE_INIT)
  ) u_nickle_inv (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .dec_i  (dec_nickle),
    .cnt_o  (nickle_cnt_o),
    .nz_o   (nickle_nz)
  );

  coin_inventory #(
    .CNT_W (CNT_W),
    .INIT  (DIME_INIT)
  ) u_dime_inv (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .dec_i  (dec_dime),
    .cnt_o  (dime_cnt_o),
    .nz_o   (dime_nz)
  );

  assign vend_o   = (state_q == ST_VEND);
  assign nickle_o = (state_q == ST_WAIT_ACK) && !coin_q;
  assign dime_o   = (state_q == ST_WAIT_ACK) && coin_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign fault_o  = (state_q == ST_FAULT);
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Self-checking bench for change_dispenser. A cents-based model of
//            a sale (vend, then pay largest affordable coin until done)
//            predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soda = 1'b0;
  logic [2:0] change = 3'd0;
  logic       coin_ack = 1'b0;
  logic       refill = 1'b0;
  logic       vend_o, nickle_o, dime_o, busy_o, fault_o, err_o;
  logic [3:0] nickle_cnt_o, dime_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .soda_i       (soda),
    .change_i     (change),
    .coin_ack_i   (coin_ack),
    .refill_i     (refill),
    .vend_o       (vend_o),
    .nickle_o     (nickle_o),
    .dime_o       (dime_o),
    .busy_o       (busy_o),
    .fault_o      (fault_o),
    .err_o        (err_o),
    .nickle_cnt_o (nickle_cnt_o),
    .dime_cnt_o   (dime_cnt_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (amounts in cents) -----------------
  // Phases of a sale: 0 idle, 1 releasing soda, 2 choosing a coin,
  // 3 waiting for the coin mechanism, 4 stalled for lack of stock.
  int m_phase, m_rem, m_coin, m_n, m_d;
  bit m_err;

  function automatic int pick_coin(int rem, int n, int d);
    if (rem >= 10 && d > 0) return 10;
    if (rem >= 5 && n > 0) return 5;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_rem = 0; m_coin = 0; m_n = 8; m_d = 8; m_err = 0;
    end else begin
      int c;
      m_err = soda && (m_phase != 0 || change > 3'd4);
      case (m_phase)
        0: begin
          if (refill) begin m_n = 8; m_d = 8; end
          if (soda) begin
            m_rem = (change <= 3'd4) ? int'(change) * 5 : 0;
            m_phase = 1;
          end
        end
        1: begin
          if (refill) begin m_n = 8; m_d = 8; end
          m_phase = 2;
        end
        2: begin
          c = pick_coin(m_rem, m_n, m_d);
          if (m_rem == 0) m_phase = 0;
          else if (c == 0) m_phase = 4;
          else begin m_coin = c; m_phase = 3; end
          if (refill) begin m_n = 8; m_d = 8; end
        end
        3: begin
          if (coin_ack) begin
            m_rem -= m_coin;
            if (m_coin == 10) m_d--; else m_n--;
            m_phase = 2;
          end
        end
        default: begin
          if (refill) begin m_n = 8; m_d = 8; m_phase = 2; end
        end
      endcase
    end
  end

  // One compare per cycle of the full output vector against the model.
  always @(negedge clk) begin
    int exp_v, act_v;
    exp_v = {m_phase == 1, m_phase == 3 && m_coin == 5, m_phase == 3 && m_coin == 10,
             m_phase != 0, m_phase == 4, m_err, m_n[3:0], m_d[3:0]};
    act_v = {vend_o, nickle_o, dime_o, busy_o, fault_o, err_o, nickle_cnt_o, dime_cnt_o};
    check("cycle_model", act_v, exp_v);
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic sale(input logic [2:0] chg);
    @(negedge clk); soda = 1'b1; change = chg;
    @(negedge clk); soda = 1'b0; change = 3'd0;
  endtask

  // Acknowledge every coin request until the sale ends or faults.
  task automatic run_sale(output int vends, output int nd, output int nn, output bit faulted);
    vends = 0; nd = 0; nn = 0; faulted = 0;
    for (int i = 0; i < 80; i++) begin
      if (!busy_o) return;
      if (fault_o) begin faulted = 1; return; end
      if (vend_o) vends++;
      if (dime_o) begin nd++; coin_ack = 1'b1; end
      else if (nickle_o) begin nn++; coin_ack = 1'b1; end
      @(negedge clk); coin_ack = 1'b0;
    end
    n_total++;
    $display("FAIL run_sale: timeout, busy_o=%0b expected 0", busy_o);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (dime_o || nickle_o) return;
      @(negedge clk);
    end
    n_total++;
    $display("FAIL wait_req: timeout, no coin request seen, expected one");
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  int v, nd, nn;
  bit flt;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", {vend_o, nickle_o, dime_o, busy_o, fault_o, err_o}, 0);
    check("rst_counts", {nickle_cnt_o, dime_cnt_o}, 8'h88);
    #2 rst_n = 1'b1;

    // Zero change: vend, no coins, idle 3 cycles after the strobe
    sale(3'd0);
    check("s0_vend", vend_o, 1);
    @(negedge clk);
    check("s0_vend_gone", vend_o, 0);
    check("s0_busy_select", busy_o, 1);
    check("s0_no_coin", nickle_o | dime_o, 0);
    @(negedge clk);
    check("s0_idle", busy_o, 0);
    check("s0_counts", {nickle_cnt_o, dime_cnt_o}, 8'h88);

    // 20c: two dimes
    sale(3'd4);
    run_sale(v, nd, nn, flt);
    check("s20_vends", v, 1);
    check("s20_dimes", nd, 2);
    check("s20_nickels", nn, 0);
    check("s20_counts", {nickle_cnt_o, dime_cnt_o}, 8'h86);

    // Drain dimes 6 -> 0, then 15c must be three nickels
    repeat (3) begin sale(3'd4); run_sale(v, nd, nn, flt); end
    check("drain_dimes", dime_cnt_o, 0);
    sale(3'd3);
    run_sale(v, nd, nn, flt);
    check("s15_nickels", nn, 3);
    check("s15_dimes", nd, 0);
    check("s15_ncnt", nickle_cnt_o, 5);

    // Nickels exhausted with dimes in stock: 5c owed cannot be paid
    do_reset();
    repeat (8) begin sale(3'd1); run_sale(v, nd, nn, flt); end
    check("drain_nickels", {nickle_cnt_o, dime_cnt_o}, 8'h08);
    sale(3'd1);
    run_sale(v, nd, nn, flt);
    check("flt_entered", flt, 1);
    check("flt_no_coins", nd + nn, 0);
    repeat (2) @(negedge clk);
    check("flt_held", {fault_o, busy_o, nickle_o, dime_o}, 4'b1100);
    refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    run_sale(v, nd, nn, flt);
    check("flt_resume_nickel", nn, 1);
    check("flt_resume_dime", nd, 0);
    check("flt_cleared", {fault_o, busy_o}, 0);
    check("flt_counts", {nickle_cnt_o, dime_cnt_o}, 8'h78);

    // Strobe while waiting on a coin: error pulse, no second vend
    sale(3'd4);
    wait_req();
    soda = 1'b1; change = 3'd1;
    @(negedge clk); soda = 1'b0; change = 3'd0;
    check("busy_err_pulse", err_o, 1);
    @(negedge clk);
    check("busy_err_clear", err_o, 0);
    run_sale(v, nd, nn, flt);
    check("busy_no_revend", v, 0);
    check("busy_dimes_total", nd, 2);

    // Out-of-range code: error pulse, vend, no change
    sale(3'd5);
    check("bad_code_err", err_o, 1);
    run_sale(v, nd, nn, flt);
    check("bad_code_vend", v, 1);
    check("bad_code_coins", nd + nn, 0);

    // Reset while a dime is requested
    sale(3'd4);
    wait_req();
    check("mid_dime_req", dime_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dime", dime_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_counts", {nickle_cnt_o, dime_cnt_o}, 8'h88);
    @(negedge clk); coin_ack = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk); coin_ack = 1'b0;
    check("late_ack_ignored", {busy_o, dime_o, nickle_o}, 0);
    check("late_ack_counts", {nickle_cnt_o, dime_cnt_o}, 8'h88);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter NICKLE_INIT, default 8, nickel count loaded on reset and refill.
REQ-002 Parameter DIME_INIT, default 8, dime count loaded on reset and refill.
REQ-003 Parameter CNT_W, default 4, width of each inventory counter; both INIT values SHALL be at most 2^CNT_W-1.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 soda_i  in  1  one-cycle sale strobe from the vending controller.
REQ-007 change_i  in  3  change owed in 5c units (000=0, 001=5c, 010=10c, 011=15c, 100=20c); valid only with soda_i.
REQ-008 coin_ack_i  in  1  coin mechanism has ejected the requested coin.
REQ-009 refill_i  in  1  one-cycle strobe that restocks both coin tubes.
REQ-010 vend_o  out  1  one-cycle soda release pulse.
REQ-011 nickle_o  out  1  request to eject one nickel, held until acknowledged.
REQ-012 dime_o  out  1  request to eject one dime, held until acknowledged.
REQ-013 busy_o  out  1  a sale is in progress.
REQ-014 fault_o  out  1  change cannot be paid from current inventory.
REQ-015 err_o  out  1  one-cycle pulse on a rejected request.
REQ-016 nickle_cnt_o, dime_cnt_o  out  CNT_W each  current inventory counts.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, VEND, SELECT, WAIT_ACK and FAULT; all outputs except err_o SHALL be Moore decodes of registered state.
REQ-018 In IDLE, soda_i with change_i <= 100 SHALL latch change_i into a 3-bit remaining register and move to VEND at that edge.
REQ-019 In IDLE, soda_i with change_i in 101..111 SHALL pulse err_o for the next cycle, latch remaining=0 and still move to VEND, so the soda is dispensed with no change.
REQ-020 VEND SHALL assert vend_o for exactly one cycle and then move to SELECT, so vend_o is high in the cycle after soda_i is sampled.
REQ-021 SELECT (one cycle, no coin output) SHALL evaluate, in priority order: remaining=0 -> IDLE; remaining>=2 and dime_cnt>0 -> WAIT_ACK with coin=dime; nickle_cnt>0 -> WAIT_ACK with coin=nickel; otherwise -> FAULT.
REQ-022 The dispenser SHALL never overpay; with remaining=1 and only dimes in stock, SELECT SHALL move to FAULT.
REQ-023 In WAIT_ACK, exactly one of dime_o or nickle_o SHALL be held high according to the latched coin type until coin_ack_i is sampled high.
REQ-024 On coin_ack_i in WAIT_ACK: remaining SHALL decrease by 2 (dime) or 1 (nickel), the matching counter SHALL decrement by 1, and the FSM SHALL return to SELECT; coin_ack_i outside WAIT_ACK SHALL be ignored.
REQ-025 FAULT SHALL hold fault_o=1 and busy_o=1; on refill_i it SHALL reload both counters and move to SELECT, resuming payment of the remaining amount.
REQ-026 refill_i in IDLE, VEND or SELECT SHALL reload both counters to NICKLE_INIT and DIME_INIT without changing state; refill_i in WAIT_ACK SHALL be ignored.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 soda_i sampled in any state other than IDLE SHALL be ignored and SHALL pulse err_o for one cycle; no second sale is queued.
REQ-029 The counters SHALL never wrap, because SELECT only chooses a coin whose count is greater than 0.

Reset
REQ-030 Asserting rst_ni (low), including mid-sale, SHALL immediately force state=IDLE, remaining=0, nickle_cnt=NICKLE_INIT and dime_cnt=DIME_INIT.
REQ-031 During reset, vend_o, nickle_o, dime_o, busy_o, fault_o and err_o SHALL all be 0; any pending coin request SHALL be abandoned.

Structure
REQ-032 A shared package vend_pkg SHALL hold the state enum, the change-code constants (CHG_0..CHG_20) and the coin values in 5c units (NICKLE_VAL=1, DIME_VAL=2).
REQ-033 One sub-module, coin_inventory, SHALL implement a single CNT_W down-counter with synchronous load, decrement and nonzero flag; change_dispenser SHALL instantiate it twice.

Verification
REQ-034 Reset, then soda_i with change_i=000 -> vend_o high for 1 cycle, no coin requests, busy_o low 3 cycles after the strobe, counts stay 8/8.
REQ-035 change_i=100 with full stock -> vend_o, then two dime_o/coin_ack_i handshakes, then IDLE; dime_cnt_o 8->6, nickle_cnt_o stays 8.
REQ-036 Dimes drained to 0, then change_i=011 -> three nickle_o handshakes, no dime_o, nickle_cnt_o 8->5.
REQ-037 nickle_cnt=0, dimes in stock, change_i=001 -> fault_o=1, busy_o=1, no coin request; then refill_i -> one nickle_o handshake, fault_o=0, IDLE.
REQ-038 soda_i during WAIT_ACK, and change_i=101 in IDLE -> err_o one-cycle pulse each; the busy case causes no extra vend; the 101 case vends with no coins.
REQ-039 rst_ni low while dime_o is held -> dime_o=0 immediately, counts reload to 8/8, and a later coin_ack_i has no effect.
